// File: rtl/axistream_unpack.sv
// axistream_unpack: width-down AXI-Stream converter. Each accepted wide word of
// NUM_PACK elements is emitted as narrow beats, one per kept element, in
// little- or big-endian element order. A new word may be accepted in the same
// cycle that the final remaining element is handed off.
module axistream_unpack #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_PACK   = 4,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         src_tvalid,
    output logic                         src_tready,
    input  logic [DATA_WIDTH*NUM_PACK-1:0] src_tdata,
    input  logic [NUM_PACK-1:0]          src_tkeep,
    input  logic                         src_tlast,
    output logic                         dest_tvalid,
    input  logic                         dest_tready,
    output logic [DATA_WIDTH-1:0]        dest_tdata,
    output logic                         dest_tlast,
    output logic                         tlast_drop_err
);

    localparam int IDX_W = (NUM_PACK > 1) ? $clog2(NUM_PACK) : 1;

    logic [DATA_WIDTH*NUM_PACK-1:0] data_buf;
    logic [NUM_PACK-1:0]            rem_keep;
    logic                           last_buf;

    logic [IDX_W-1:0]               sel_idx;
    logic [NUM_PACK-1:0]            sel_mask;
    logic                           rem_one_hot;
    logic                           src_accept;
    logic                           dest_handoff;

    // Pick the next element to emit: lowest kept bit first for little-endian,
    // highest kept bit first for big-endian.
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        sel_idx = '0;
        if (BIG_ENDIAN) begin
            for (int i = 0; i < NUM_PACK; i++) begin
                if (rem_keep[i]) sel_idx = IDX_W'(i);
            end
        end else begin
            for (int i = NUM_PACK - 1; i >= 0; i--) begin
                if (rem_keep[i]) sel_idx = IDX_W'(i);
            end
        end
    end

    assign sel_mask     = NUM_PACK'(1) << sel_idx;
    assign rem_one_hot  = (rem_keep != '0) && ((rem_keep & (rem_keep - NUM_PACK'(1))) == '0);

    assign dest_tvalid  = |rem_keep;
    assign dest_tdata   = data_buf[sel_idx*DATA_WIDTH +: DATA_WIDTH];
    assign dest_tlast   = last_buf && rem_one_hot;

    // Ready when empty, or when the only remaining element leaves this cycle.
    assign src_tready   = !rst && ((rem_keep == '0) || (dest_tready && rem_one_hot));
    assign src_accept   = src_tvalid && src_tready;
    assign dest_handoff = dest_tvalid && dest_tready;

    // Control state: load a new word on accept, otherwise retire the emitted element.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_keep       <= '0;
            last_buf       <= 1'b0;
            tlast_drop_err <= 1'b0;
        end else begin
            tlast_drop_err <= src_accept && (src_tkeep == '0) && src_tlast;
            if (src_accept) begin
                rem_keep <= src_tkeep;
                last_buf <= src_tlast;
            end else if (dest_handoff) begin
                rem_keep <= rem_keep & ~sel_mask;
            end
        end
    end

    // Word storage, loaded on every accept.
    // NOTE: data_buf is deliberately not reset; rem_keep gates whether it is ever observed.
    always_ff @(posedge clk) begin
        if (src_accept) data_buf <= src_tdata;
    end

endmodule
